// File: rtl/bin_to_7seg_seq.sv
// bin_to_7seg_seq: iterative double-dabble binary to 7-segment driver.
// Ports: clk, rst (async high), in_valid/in_ready handshake, data_in,
//   out_valid pulse, seg_out {g..a} per digit, sig (1=+), ovf.
module bin_to_7seg_seq #(
    parameter int DATA_W     = 16,
    parameter int NUM_DIG    = 5,
    parameter bit SIGNED     = 1'b1,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    data_in,
    output logic                 out_valid,
    output logic [7*NUM_DIG-1:0] seg_out,
    output logic                 sig,
    output logic                 ovf
);

    // One guard nibble above the displayed digits flags overflow.
    localparam int BW = 4 * (NUM_DIG + 1);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [6:0] BLANK7 = ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t               state_q;
    logic [BW-1:0]        bcd_q, bcd_adj, bcd_d;
    logic [DATA_W-1:0]    mag_q, mag_d, mag_in;
    logic [CW-1:0]        cnt_q;
    logic                 sign_q;
    logic                 sticky_q;
    logic                 out_valid_q;
    logic [7*NUM_DIG-1:0] seg_q, seg_d;
    logic                 sig_q;
    logic                 ovf_q, ovf_d;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'b0111111;
            4'd1:    enc = 7'b0000110;
            4'd2:    enc = 7'b1011011;
            4'd3:    enc = 7'b1001111;
            4'd4:    enc = 7'b1100110;
            4'd5:    enc = 7'b1101101;
            4'd6:    enc = 7'b1111101;
            4'd7:    enc = 7'b0000111;
            4'd8:    enc = 7'b1111111;
            4'd9:    enc = 7'b1101111;
            default: enc = 7'b0000000;
        endcase
    endfunction

    // Two's complement negate; the most negative value maps to 2^(W-1).
    assign mag_in = (SIGNED && data_in[DATA_W-1])
                  ? (~data_in + DATA_W'(1))
                  : data_in;

    // Add-3 on every nibble >= 5, then shift {bcd, mag} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIG + 1; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_d = {bcd_adj[BW-2:0], mag_q[DATA_W-1]};
        mag_d = {mag_q[DATA_W-2:0], 1'b0};
    end

    // Segment patterns from the finished BCD value.
    always_comb begin
        logic       lead;
        logic [3:0] dig;
        logic [6:0] pat;
        lead  = 1'b1;
        dig   = '0;
        pat   = '0;
        seg_d = '0;
        // sticky_q catches digits shifted out above the guard nibble
        ovf_d = sticky_q | (|bcd_q[BW-1 -: 4]);
        for (int k = NUM_DIG - 1; k >= 0; k--) begin
            dig = bcd_q[4*k +: 4];
            if (dig != 4'd0)
                lead = 1'b0;
            if (ovf_d)
                pat = 7'b1000000;
            else if (BLANK_LZ && lead && (k != 0))
                pat = 7'b0000000;
            else
                pat = enc(dig);
            seg_d[7*k +: 7] = ACTIVE_LOW ? ~pat : pat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bcd_q       <= '0;
            mag_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            seg_q       <= {NUM_DIG{BLANK7}};
            sig_q       <= 1'b1;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= SIGNED && data_in[DATA_W-1];
                        mag_q    <= mag_in;
                        bcd_q    <= '0;
                        sticky_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= CONV;
                    end
                end
                CONV: begin
                    bcd_q    <= bcd_d;
                    mag_q    <= mag_d;
                    sticky_q <= sticky_q | bcd_adj[BW-1];
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(DATA_W - 1))
                        state_q <= DONE;
                end
                DONE: begin
                    seg_q       <= seg_d;
                    sig_q       <= ~sign_q;
                    ovf_q       <= ovf_d;
                    out_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign seg_out   = seg_q;
    assign sig       = sig_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin_to_7seg_seq.sv
// tb_bin_to_7seg_seq: directed checks of bin_to_7seg_seq.
// Instance u0 uses defaults; u1 is unsigned with four digits.
module tb_bin_to_7seg_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] data_in = '0;

    logic        rdy0, ov0, sg0, of0;
    logic [34:0] seg0;
    logic        rdy1, ov1, sg1, of1;
    logic [27:0] seg1;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [6:0] BL = 7'h7F;

    always #5 clk = ~clk;

    bin_to_7seg_seq u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .data_in(data_in), .out_valid(ov0), .seg_out(seg0),
        .sig(sg0), .ovf(of0)
    );

    bin_to_7seg_seq #(.SIGNED(1'b0), .NUM_DIG(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .data_in(data_in), .out_valid(ov1), .seg_out(seg1),
        .sig(sg1), .ovf(of1)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse in_valid for one edge, then count edges to out_valid.
    task automatic run(input logic [15:0] v, output int lat);
        data_in  = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!ov0 && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    int lat;
    int e;
    int nout;
    int oe[3];
    logic [34:0] os[3];

    initial begin
        // reset state
        #12;
        check("rst_seg", seg0, {5{BL}});
        check("rst_vld", ov0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rel_seg", seg0, {5{BL}});
        check("rel_sig", sg0, 1);
        check("rel_ovf", of0, 0);
        check("rel_rdy", rdy0, 1);
        check("rel_seg1", seg1, {4{BL}});

        // most negative input
        run(16'h8000, lat);
        check("neg_lat", lat, 17);
        check("neg_seg", seg0, {7'h30, 7'h24, 7'h78, 7'h02, 7'h00});
        check("neg_sig", sg0, 0);
        check("neg_ovf", of0, 0);
        check("neg_rdy", rdy0, 1);
        @(posedge clk);
        #1 check("neg_pulse", ov0, 0);

        // zero and small negative
        run(16'd0, lat);
        check("zero_seg", seg0, {BL, BL, BL, BL, 7'h40});
        check("zero_sig", sg0, 1);
        run(16'hFFF9, lat);
        check("m7_seg", seg0, {BL, BL, BL, BL, 7'h78});
        check("m7_sig", sg0, 0);

        // overflow on the 4-digit unsigned instance
        run(16'd12345, lat);
        check("ovf_flag", of1, 1);
        check("ovf_seg", seg1, {4{7'h3F}});
        check("ovf_sig", sg1, 1);
        check("u0_12345", seg0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
        check("u0_nf", of0, 0);
        run(16'd9999, lat);
        check("9999_ovf", of1, 0);
        check("9999_seg", seg1, {4{7'h10}});
        check("u0_9999", seg0, {BL, 7'h10, 7'h10, 7'h10, 7'h10});

        // back-to-back with in_valid held high
        @(posedge clk);
        #1;
        data_in  = 16'd1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 data_in = 16'd2;
        nout = 0;
        for (e = 1; e <= 60 && nout < 3; e++) begin
            @(posedge clk);
            #1;
            if (ov0) begin
                oe[nout] = e;
                os[nout] = seg0;
                nout++;
            end else if (nout == 1) begin
                data_in = 16'd3;
            end else if (nout == 2) begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("b2b_cnt", nout, 3);
        check("b2b_e1", oe[0], 17);
        check("b2b_e2", oe[1], 35);
        check("b2b_e3", oe[2], 53);
        check("b2b_v1", os[0], {BL, BL, BL, BL, 7'h79});
        check("b2b_v2", os[1], {BL, BL, BL, BL, 7'h24});
        check("b2b_v3", os[2], {BL, BL, BL, BL, 7'h30});

        // reset in the middle of a conversion
        @(posedge clk);
        #1;
        data_in  = 16'd1234;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("ab_seg", seg0, {5{BL}});
        check("ab_vld", ov0, 0);
        check("ab_rdy", rdy0, 1);
        check("ab_sig", sg0, 1);
        nout = 0;
        repeat (2) begin
            @(posedge clk);
            #1 if (ov0) nout++;
        end
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1 if (ov0) nout++;
        end
        check("ab_novld", nout, 0);
        check("ab_hold", seg0, {5{BL}});
        run(16'd1234, lat);
        check("post_lat", lat, 17);
        check("post_seg", seg0, {BL, 7'h79, 7'h24, 7'h30, 7'h19});
        check("post_sig", sg0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
